// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: hex decode, leading-zero
// blanking, PWM brightness and a frame-synchronous LOAD/ACK value update.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no captured value waiting; shown value is current
// ST_PEND | a captured value waits for the next frame boundary
module seg7_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV_LOG2 = 14,
    parameter int BRIGHT_W      = 3
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [4*NUM_DIGITS-1:0]   DATA_IN,
    input  logic [NUM_DIGITS-1:0]     DP_IN,
    input  logic                      LOAD,
    input  logic                      LZB,
    input  logic [BRIGHT_W-1:0]       BRIGHT,
    output logic                      BUSY,
    output logic                      LOAD_ACK,
    output logic [NUM_DIGITS-1:0]     DIG,
    output logic [7:0]                SEG
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SCAN_DIV_LOG2-1:0] div_cnt;
    logic [IDX_W-1:0]         dig_idx;
    logic                     div_wrap;
    logic                     idx_last;
    logic                     frame_bnd;

    logic                     take_pend;
    logic                     commit_in;
    logic                     commit_pend;
    logic                     busy_int;

    logic [4*NUM_DIGITS-1:0]  shown_data;
    logic [NUM_DIGITS-1:0]    shown_dp;
    logic [4*NUM_DIGITS-1:0]  pend_data;
    logic [NUM_DIGITS-1:0]    pend_dp;
    logic                     ack_q;

    logic [NUM_DIGITS-1:0]    blank_vec;
    logic                     upper_zero;
    logic [3:0]               cur_nib;
    logic                     cur_dp;
    logic                     cur_blank;
    logic [NUM_DIGITS-1:0]    dig_sel;
    logic                     slot_on;
    logic [NUM_DIGITS-1:0]    dig_nxt;
    logic [7:0]               seg_nxt;

    // Segment pattern for g..a, active-low, dp not included.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign div_wrap  = &div_cnt;
    assign idx_last  = (dig_idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_bnd = div_wrap & idx_last;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_wrap) begin
                dig_idx <= idx_last ? '0 : dig_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (LOAD && !frame_bnd) state_nxt = ST_PEND;
            ST_PEND: if (frame_bnd)          state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // A LOAD on the boundary cycle goes straight to the display and wins
    // over any older pending value.
    always_comb begin
        take_pend   = 1'b0;
        commit_in   = 1'b0;
        commit_pend = 1'b0;
        busy_int    = (state == ST_PEND);
        if (LOAD) begin
            if (frame_bnd) begin
                commit_in = 1'b1;
            end else begin
                take_pend = 1'b1;
            end
        end else if (frame_bnd && state == ST_PEND) begin
            commit_pend = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shown_data <= '0;
            shown_dp   <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= commit_in | commit_pend;
            if (take_pend) begin
                pend_data <= DATA_IN;
                pend_dp   <= DP_IN;
            end
            if (commit_in) begin
                shown_data <= DATA_IN;
                shown_dp   <= DP_IN;
            end else if (commit_pend) begin
                shown_data <= pend_data;
                shown_dp   <= pend_dp;
            end
        end
    end

    assign BUSY     = busy_int;
    assign LOAD_ACK = ack_q;

    // Walk from the most significant nibble down; digit 0 is never blanked.
    always_comb begin
        upper_zero = 1'b1;
        blank_vec  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (shown_data[4*k +: 4] == 4'h0);
            if (k > 0) begin
                blank_vec[k] = LZB & upper_zero;
            end
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        dig_sel   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_idx == IDX_W'(k)) begin
                cur_nib    = shown_data[4*k +: 4];
                cur_dp     = shown_dp[k];
                cur_blank  = blank_vec[k];
                dig_sel[k] = 1'b0;
            end
        end
    end

    // div_cnt==0 is kept dark so the previous digit never ghosts into the next.
    always_comb begin
        slot_on = (div_cnt != '0) &&
                  (div_cnt[SCAN_DIV_LOG2-1 -: BRIGHT_W] <= BRIGHT);
        dig_nxt = '1;
        seg_nxt = 8'hFF;
        if (slot_on) begin
            dig_nxt = dig_sel;
            seg_nxt = {~cur_dp, cur_blank ? 7'h7F : hex_to_seg(cur_nib)};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DIG <= '1;
            SEG <= 8'hFF;
        end else begin
            DIG <= dig_nxt;
            SEG <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (4 digits, 16-cycle slots, 2-bit brightness).
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BW = 2;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b1;
    logic [4*ND-1:0] DATA_IN;
    logic [ND-1:0]   DP_IN;
    logic            LOAD;
    logic            LZB;
    logic [BW-1:0]   BRIGHT;
    logic            BUSY;
    logic            LOAD_ACK;
    logic [ND-1:0]   DIG;
    logic [7:0]      SEG;

    seg7_scan_mux #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV_LOG2(SD),
        .BRIGHT_W     (BW)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .DATA_IN (DATA_IN),
        .DP_IN   (DP_IN),
        .LOAD    (LOAD),
        .LZB     (LZB),
        .BRIGHT  (BRIGHT),
        .BUSY    (BUSY),
        .LOAD_ACK(LOAD_ACK),
        .DIG     (DIG),
        .SEG     (SEG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] dig;
        logic [7:0] seg;
        logic       busy;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // cyc = posedges since reset release; outputs seen at cyc n reflect count n-1.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push_exp(input int at, input string name, input logic [3:0] dig,
                            input logic [7:0] seg, input logic busy, input logic ack);
        exp_t e;
        e.at = at; e.name = name; e.dig = dig; e.seg = seg; e.busy = busy; e.ack = ack;
        sb_q.push_back(e);
    endtask

    // One frame (64 cycles) of expectations; segs holds the hand-decoded digit codes.
    task automatic exp_frame(input string name, input int frame, input int last,
                             input logic [3:0][7:0] segs, input int bright,
                             input int busy_lo, input int busy_hi, input int ack_at);
        int n, cnt, dv, ix;
        bit on;
        logic [3:0] dg;
        for (int j = 1; j <= last; j++) begin
            n   = frame * 64 + j;
            cnt = n - 1;
            dv  = cnt % 16;
            ix  = (cnt / 16) % 4;
            on  = (dv != 0) && ((dv / 4) <= bright);
            dg  = 4'b0001 << ix;
            dg  = ~dg;
            push_exp(n, name, on ? dg : 4'hF, on ? segs[ix] : 8'hFF,
                     (n >= busy_lo) && (n <= busy_hi), n == ack_at);
        end
    endtask

    always @(negedge CLK) begin
        while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                     sb_q[0].name, sb_q[0].at, cyc);
            void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (DIG !== mon_e.dig || SEG !== mon_e.seg ||
                BUSY !== mon_e.busy || LOAD_ACK !== mon_e.ack) begin
                errors++;
                $display("FAIL %s cyc %0d: got DIG=%b SEG=%h BUSY=%b ACK=%b, want DIG=%b SEG=%h BUSY=%b ACK=%b",
                         mon_e.name, cyc, DIG, SEG, BUSY, LOAD_ACK,
                         mon_e.dig, mon_e.seg, mon_e.busy, mon_e.ack);
            end
        end
    end

    task automatic to_cyc(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic pulse_load();
        LOAD = 1'b1;
        @(posedge CLK);
        #2;
        LOAD = 1'b0;
    endtask

    initial begin
        int guard;
        DATA_IN = '0;
        DP_IN   = '0;
        LOAD    = 1'b0;
        LZB     = 1'b0;
        BRIGHT  = 2'd3;

        for (int i = 0; i < 3; i++) push_exp(0, "reset", 4'hF, 8'hFF, 1'b0, 1'b0);
        exp_frame("idle_zero",  0, 64, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 3, -1, -2, -1);
        exp_frame("load_pend",  1, 64, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 3, 81, 127, 128);
        exp_frame("show_12AF",  2, 64, {8'hF9, 8'h24, 8'h88, 8'h8E}, 3, -1, -2, -1);
        exp_frame("lzb_load",   3, 64, {8'hF9, 8'h24, 8'h88, 8'h8E}, 3, 201, 255, 256);
        exp_frame("lzb_0030",   4, 64, {8'hFF, 8'hFF, 8'hB0, 8'hC0}, 3, 271, 319, 320);
        exp_frame("lzb_dp3",    5, 64, {8'h7F, 8'hFF, 8'hB0, 8'hC0}, 3, -1, -2, -1);
        exp_frame("two_loads",  6, 64, {8'h7F, 8'hFF, 8'hB0, 8'hC0}, 3, 391, 447, 448);
        exp_frame("show_2222",  7, 64, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 3, -1, -2, -1);
        exp_frame("bnd_load",   8, 64, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 3, -1, -2, 576);
        exp_frame("show_3333",  9, 64, {8'hB0, 8'hB0, 8'hB0, 8'hB0}, 3, -1, -2, -1);
        exp_frame("bright0",   10, 64, {8'hB0, 8'hB0, 8'hB0, 8'hB0}, 0, -1, -2, -1);
        exp_frame("bright1",   11, 64, {8'hB0, 8'hB0, 8'hB0, 8'hB0}, 1, -1, -2, -1);
        exp_frame("pre_rst",   12, 22, {8'hB0, 8'hB0, 8'hB0, 8'hB0}, 3, 781, 790, -1);
        for (int i = 0; i < 4; i++) push_exp(0, "mid_reset", 4'hF, 8'hFF, 1'b0, 1'b0);
        exp_frame("post_rst0",  0, 64, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 3, -1, -2, -1);
        exp_frame("post_rst1",  1, 64, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 3, -1, -2, -1);

        #1 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;

        to_cyc(80);
        DATA_IN = 16'h12AF; DP_IN = 4'b0100;
        pulse_load();

        to_cyc(200);
        LZB = 1'b1; DATA_IN = 16'h0030; DP_IN = 4'b0000;
        pulse_load();

        to_cyc(270);
        DP_IN = 4'b1000;
        pulse_load();

        to_cyc(390);
        DATA_IN = 16'h1111; DP_IN = 4'b0000;
        pulse_load();
        to_cyc(420);
        DATA_IN = 16'h2222;
        pulse_load();

        to_cyc(575);
        DATA_IN = 16'h3333;
        pulse_load();

        to_cyc(640);
        BRIGHT = 2'd0;
        to_cyc(704);
        BRIGHT = 2'd1;
        to_cyc(768);
        BRIGHT = 2'd3;

        to_cyc(780);
        DATA_IN = 16'h5555; DP_IN = 4'b1111;
        pulse_load();

        to_cyc(791);
        RST_N = 1'b0;
        LZB   = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;

        guard = 0;
        while (sb_q.size() > 0 && guard < 400) begin
            @(posedge CLK);
            guard++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
